// File: rtl/wb_regfile.sv
// Writeback stage: selects ALU vs load data, commits it to the 32-entry integer
// register file, serves two combinational decode read ports with same-cycle
// bypass, and counts writeback-enabled cycles for the retire counter.
module wb_regfile #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned RegAddrWidth = 5,
    parameter int unsigned CountWidth   = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wb_reg_en,
    input  logic [DataWidth-1:0]    wb_alu_result,
    input  logic [DataWidth-1:0]    wb_mem_data,
    input  logic [RegAddrWidth-1:0] wb_rd,
    input  logic                    wb_mem_to_reg,
    input  logic [RegAddrWidth-1:0] rs1_addr,
    input  logic [RegAddrWidth-1:0] rs2_addr,
    output logic [DataWidth-1:0]    rs1_data,
    output logic [DataWidth-1:0]    rs2_data,
    output logic [DataWidth-1:0]    wb_data,
    output logic [CountWidth-1:0]   retire_count
);

    localparam int unsigned NumRegs = 2 ** RegAddrWidth;

    logic [DataWidth-1:0]  regs_q [NumRegs];
    logic [CountWidth-1:0] retire_q;
    logic [CountWidth-1:0] retire_d;
    logic                  wr_en;

    // Writeback data select; a pure mux, load data arrives already extended.
    always_comb begin
        wb_data = wb_mem_to_reg ? wb_mem_data : wb_alu_result;
    end

    // x0 is never written, so it stays at its reset value of zero.
    always_comb begin
        wr_en = wb_reg_en && (wb_rd != '0);
    end

    // Register array: synchronous clear on reset, otherwise commit the writeback.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    // Read port 1: zero under reset, bypass the in-flight write, x0 reads zero.
    always_comb begin
        rs1_data = '0;
        if (!reset) begin
            if (wr_en && (rs1_addr == wb_rd)) begin
                rs1_data = wb_data;
            end else if (rs1_addr != '0) begin
                rs1_data = regs_q[rs1_addr];
            end
        end
    end

    // Read port 2: identical selection to port 1.
    always_comb begin
        rs2_data = '0;
        if (!reset) begin
            if (wr_en && (rs2_addr == wb_rd)) begin
                rs2_data = wb_data;
            end else if (rs2_addr != '0) begin
                rs2_data = regs_q[rs2_addr];
            end
        end
    end

    // Retire counter next state: rd=0 writes still retire; wraps silently.
    always_comb begin
        retire_d = retire_q;
        if (wb_reg_en) begin
            retire_d = retire_q + CountWidth'(1);
        end
    end

    // Retire counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_count = retire_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile. A second instance with a 4-bit
// retire counter shares all inputs so that counter wrap can be reached quickly.
module tb_wb_regfile;

    logic        clock;
    logic        reset;
    logic        wb_reg_en;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_mem_data;
    logic [4:0]  wb_rd;
    logic        wb_mem_to_reg;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_data;
    logic [63:0] retire_count;

    logic [31:0] s_rs1_data;
    logic [31:0] s_rs2_data;
    logic [31:0] s_wb_data;
    logic [3:0]  s_retire_count;

    int total  = 0;
    int passed = 0;

    wb_regfile dut (
        .clock         (clock),
        .reset         (reset),
        .wb_reg_en     (wb_reg_en),
        .wb_alu_result (wb_alu_result),
        .wb_mem_data   (wb_mem_data),
        .wb_rd         (wb_rd),
        .wb_mem_to_reg (wb_mem_to_reg),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .wb_data       (wb_data),
        .retire_count  (retire_count)
    );

    wb_regfile #(
        .CountWidth (4)
    ) dut_small (
        .clock         (clock),
        .reset         (reset),
        .wb_reg_en     (wb_reg_en),
        .wb_alu_result (wb_alu_result),
        .wb_mem_data   (wb_mem_data),
        .wb_rd         (wb_rd),
        .wb_mem_to_reg (wb_mem_to_reg),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (s_rs1_data),
        .rs2_data      (s_rs2_data),
        .wb_data       (s_wb_data),
        .retire_count  (s_retire_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        wb_reg_en     = 1'b0;
        wb_alu_result = '0;
        wb_mem_data   = '0;
        wb_rd         = '0;
        wb_mem_to_reg = 1'b0;
        rs1_addr      = '0;
        rs2_addr      = '0;
        step();
        step();
        check("init_count", retire_count, 64'd0);

        // 1. Preload two registers, then reset clears them
        reset = 1'b0;
        wb_reg_en = 1'b1; wb_rd = 5'd3; wb_alu_result = 32'hAAAA_0003;
        step();
        wb_rd = 5'd4; wb_alu_result = 32'h0000_0044;
        step();
        wb_reg_en = 1'b0; rs1_addr = 5'd3; rs2_addr = 5'd4;
        #1;
        check("preload_rs1", {32'd0, rs1_data}, 64'hAAAA_0003);
        check("preload_rs2", {32'd0, rs2_data}, 64'h0000_0044);
        check("preload_count", retire_count, 64'd2);
        reset = 1'b1;
        #1;
        check("rst_rs1_forced", {32'd0, rs1_data}, 64'd0);
        check("rst_wb_data_mux", {32'd0, wb_data}, 64'h0000_0044);
        step();
        reset = 1'b0;
        #1;
        check("rst_rs1", {32'd0, rs1_data}, 64'd0);
        check("rst_rs2", {32'd0, rs2_data}, 64'd0);
        check("rst_count", retire_count, 64'd0);

        // 2. Mux select and commit
        wb_reg_en = 1'b1; wb_rd = 5'd5; wb_alu_result = 32'h1234_5678;
        wb_mem_data = 32'hDEAD_BEEF; wb_mem_to_reg = 1'b0;
        #1;
        check("mux_alu", {32'd0, wb_data}, 64'h1234_5678);
        step();
        wb_reg_en = 1'b0; rs1_addr = 5'd5;
        #1;
        check("commit_alu", {32'd0, rs1_data}, 64'h1234_5678);
        wb_reg_en = 1'b1; wb_mem_to_reg = 1'b1;
        #1;
        check("mux_mem", {32'd0, wb_data}, 64'hDEAD_BEEF);
        check("bypass_mem", {32'd0, rs1_data}, 64'hDEAD_BEEF);
        step();
        wb_reg_en = 1'b0;
        #1;
        check("commit_mem", {32'd0, rs1_data}, 64'hDEAD_BEEF);
        check("count_after_mux", retire_count, 64'd2);

        // 3. Bypass on both ports
        wb_reg_en = 1'b1; wb_rd = 5'd7; wb_alu_result = 32'h11; wb_mem_to_reg = 1'b0;
        step();
        wb_alu_result = 32'h22; rs1_addr = 5'd7; rs2_addr = 5'd7;
        #1;
        check("bypass_rs1", {32'd0, rs1_data}, 64'h22);
        check("bypass_rs2", {32'd0, rs2_data}, 64'h22);
        step();
        wb_reg_en = 1'b0;
        #1;
        check("after_bypass_rs1", {32'd0, rs1_data}, 64'h22);
        check("after_bypass_rs2", {32'd0, rs2_data}, 64'h22);

        // Back-to-back writes to the same rd: last wins
        wb_reg_en = 1'b1; wb_rd = 5'd8; wb_alu_result = 32'h81;
        step();
        wb_alu_result = 32'h82; rs1_addr = 5'd8; rs2_addr = 5'd7;
        #1;
        check("b2b_bypass", {32'd0, rs1_data}, 64'h82);
        check("b2b_other_port", {32'd0, rs2_data}, 64'h22);
        step();
        wb_reg_en = 1'b0;
        #1;
        check("b2b_commit", {32'd0, rs1_data}, 64'h82);
        check("count_b2b", retire_count, 64'd6);

        // 4. x0 stays zero, but the write still retires
        wb_reg_en = 1'b1; wb_rd = 5'd0; wb_alu_result = 32'hFFFF_FFFF; rs1_addr = 5'd0;
        #1;
        check("x0_same_cycle", {32'd0, rs1_data}, 64'd0);
        step();
        wb_reg_en = 1'b0;
        #1;
        check("x0_next_cycle", {32'd0, rs1_data}, 64'd0);
        check("x0_count", retire_count, 64'd7);

        // 5. Bubbles hold, writes count, small counter wraps
        for (int i = 0; i < 3; i++) step();
        check("bubble_count", retire_count, 64'd7);
        wb_reg_en = 1'b1; wb_rd = 5'd10; wb_alu_result = 32'h10;
        for (int i = 0; i < 5; i++) step();
        check("five_writes", retire_count, 64'd12);
        check("small_count", {60'd0, s_retire_count}, 64'd12);
        for (int i = 0; i < 3; i++) step();
        check("small_all_ones", {60'd0, s_retire_count}, 64'd15);
        step();
        check("small_wrap", {60'd0, s_retire_count}, 64'd0);
        check("big_no_wrap", retire_count, 64'd16);

        // 6. Reset coincident with a write discards it
        wb_rd = 5'd9; wb_alu_result = 32'hA5A5_A5A5; reset = 1'b1;
        step();
        reset = 1'b0; wb_reg_en = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd9;
        #1;
        check("rst_write_lost", {32'd0, rs2_data}, 64'd0);
        check("rst_mid_rs1", {32'd0, rs1_data}, 64'd0);
        check("rst_mid_count", retire_count, 64'd0);
        check("rst_mid_small", {60'd0, s_retire_count}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
